// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning matrix keypad controller with press/release debounce
module keypad_scanner #(
    parameter int N_COLS   = 4,
    parameter int N_ROWS   = 4,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3,
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_ROWS-1:0] rows,
    output logic [N_COLS-1:0] cols,
    output logic              key_valid,
    output logic [RW-1:0]     key_row,
    output logic [CW-1:0]     key_col,
    output logic              key_held,
    output logic              key_release
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     tick_cnt_q;
    logic [N_ROWS-1:0] rows_meta_q;
    logic [N_ROWS-1:0] rows_s_q;
    logic [CW-1:0]     col_idx_q;
    logic [RW-1:0]     row_lat_q;
    logic [DW-1:0]     db_cnt_q;
    logic [RW-1:0]     key_row_q;
    logic [CW-1:0]     key_col_q;
    logic              key_valid_q;
    logic              key_release_q;
    logic              key_held_q;

    logic              tick;
    logic              row_any;
    logic [RW-1:0]     low_row;
    logic              lat_high;
    logic [CW-1:0]     col_next;
    logic              db_last;

    assign tick     = (tick_cnt_q == TW'(SCAN_DIV - 1));
    assign row_any  = |rows_s_q;
    assign lat_high = rows_s_q[row_lat_q];
    assign col_next = (col_idx_q == CW'(N_COLS - 1)) ? '0 : col_idx_q + CW'(1);
    assign db_last  = (db_cnt_q == DW'(DEBOUNCE - 1));

    // Lowest-numbered active row wins when several rows in one column are high
    always_comb begin
        low_row = '0;
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (rows_s_q[r]) begin
                low_row = RW'(r);
            end
        end
    end

    // One-hot column drive from the current scan index (index never exceeds N_COLS-1)
    always_comb begin
        cols            = '0;
        cols[col_idx_q] = 1'b1;
    end

    // Synchronizer, scan tick divider and scan/debounce FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SCAN;
            tick_cnt_q    <= '0;
            rows_meta_q   <= '0;
            rows_s_q      <= '0;
            col_idx_q     <= '0;
            row_lat_q     <= '0;
            db_cnt_q      <= '0;
            key_row_q     <= '0;
            key_col_q     <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_held_q    <= 1'b0;
        end else begin
            rows_meta_q   <= rows;
            rows_s_q      <= rows_meta_q;
            tick_cnt_q    <= tick ? '0 : tick_cnt_q + TW'(1);
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (row_any) begin
                            row_lat_q <= low_row;
                            db_cnt_q  <= DW'(1);
                            if (DEBOUNCE == 1) begin
                                state_q     <= HELD;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                key_row_q   <= low_row;
                                key_col_q   <= col_idx_q;
                            end else begin
                                state_q <= PRESS_DB;
                            end
                        end else begin
                            col_idx_q <= col_next;
                        end
                    end
                    PRESS_DB: begin
                        if (lat_high) begin
                            db_cnt_q <= db_cnt_q + DW'(1);
                            if (db_last) begin
                                state_q     <= HELD;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                key_row_q   <= row_lat_q;
                                key_col_q   <= col_idx_q;
                            end
                        end else begin
                            state_q   <= SCAN;
                            col_idx_q <= col_next;
                        end
                    end
                    HELD: begin
                        // Only the latched key is watched; other rows are ignored
                        if (!lat_high) begin
                            db_cnt_q <= DW'(1);
                            if (DEBOUNCE == 1) begin
                                state_q       <= SCAN;
                                key_release_q <= 1'b1;
                                key_held_q    <= 1'b0;
                                col_idx_q     <= col_next;
                            end else begin
                                state_q <= RELEASE_DB;
                            end
                        end
                    end
                    RELEASE_DB: begin
                        if (!lat_high) begin
                            db_cnt_q <= db_cnt_q + DW'(1);
                            if (db_last) begin
                                state_q       <= SCAN;
                                key_release_q <= 1'b1;
                                key_held_q    <= 1'b0;
                                col_idx_q     <= col_next;
                            end
                        end else begin
                            state_q <= HELD;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_held    = key_held_q;
    assign key_row     = key_row_q;
    assign key_col     = key_col_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [1:0] key_row;
    logic [1:0] key_col;
    logic       key_held;
    logic       key_release;

    // bit r*4+c set means the key at row r, column c is pressed
    logic [15:0] keys;

    typedef struct packed {
        logic       rel;
        logic [1:0] row;
        logic [1:0] col;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_cmp     = 0;
    int  n_bad     = 0;
    int  rel_count = 0;
    int  rel_before;

    keypad_scanner #(
        .N_COLS  (4),
        .N_ROWS  (4),
        .SCAN_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rows       (rows),
        .cols       (cols),
        .key_valid  (key_valid),
        .key_row    (key_row),
        .key_col    (key_col),
        .key_held   (key_held),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row line is high when a pressed key sits in the driven column
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++) begin
            rows[r] = |(keys[r*4 +: 4] & cols);
        end
    end

    // Monitor: every press/release pulse must match the next expected event
    always @(negedge clk) begin
        if (key_valid && key_release) begin
            n_cmp++;
            n_bad++;
            $display("FAIL both_pulses: key_valid and key_release high together");
        end else if (key_valid || key_release) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got valid=%0b release=%0b row=%0d col=%0d, required no pulse",
                         key_valid, key_release, key_row, key_col);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.rel !== key_release || mon_e.row !== key_row || mon_e.col !== key_col) begin
                    n_bad++;
                    $display("FAIL event: got release=%0b row=%0d col=%0d, required release=%0b row=%0d col=%0d",
                             key_release, key_row, key_col, mon_e.rel, mon_e.row, mon_e.col);
                end
            end
        end
        if (key_release) rel_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic val, input int budget, input string name);
        int i = 0;
        while (key_held !== val && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(key_held), 32'(val));
    endtask

    task automatic wait_cols(input logic [3:0] val, input logic want_eq, input int budget, input string name);
        int i = 0;
        while (((cols === val) != want_eq) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(cols === val), 32'(want_eq));
    endtask

    task automatic push(input logic rel, input logic [1:0] row, input logic [1:0] col);
        ev_t e;
        e.rel = rel;
        e.row = row;
        e.col = col;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        check("reset_cols", 32'(cols), 32'h1);
        check("reset_outs", 32'({key_valid, key_held, key_release, key_row, key_col}), 32'h0);

        // Idle scan: each column driven for four cycles, wrapping to column 0
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("idle_cols%0d", i), 32'(cols), 32'(1 << ((i / 4) % 4)));
            @(negedge clk);
        end

        // Press row 2 / column 1
        push(1'b0, 2'd2, 2'd1);
        keys[2*4+1] = 1'b1;
        wait_held(1'b1, 200, "press_held");
        repeat (12) @(negedge clk);
        check("press_cols_frozen", 32'(cols), 32'h2);
        check("press_row", 32'(key_row), 32'd2);
        check("press_col", 32'(key_col), 32'd1);
        check("press_held_level", 32'(key_held), 32'h1);

        // One-tick release glitch: low for exactly 4 samples hits exactly one tick
        keys = '0;
        repeat (4) @(negedge clk);
        keys[2*4+1] = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_still_held", 32'(key_held), 32'h1);
        check("glitch_cols", 32'(cols), 32'h2);

        // Real release
        push(1'b1, 2'd2, 2'd1);
        keys = '0;
        wait_held(1'b0, 200, "release_done");
        check("release_next_col", 32'(cols), 32'h4);

        // Bounce: row 2 visible in column 1 for one tick only
        wait_cols(4'b0010, 1'b1, 100, "bounce_reach_col1");
        keys[2*4+1] = 1'b1;
        repeat (4) @(negedge clk);
        keys = '0;
        wait_cols(4'b0010, 1'b0, 40, "bounce_leave_col1");
        check("bounce_next_col", 32'(cols), 32'h4);
        check("bounce_not_held", 32'(key_held), 32'h0);

        // Multi-row: rows 1 and 3 in column 2 resolve to row 1
        push(1'b0, 2'd1, 2'd2);
        keys[1*4+2] = 1'b1;
        keys[3*4+2] = 1'b1;
        wait_held(1'b1, 200, "multi_held");
        check("multi_row", 32'(key_row), 32'd1);
        check("multi_col", 32'(key_col), 32'd2);
        push(1'b1, 2'd1, 2'd2);
        keys = '0;
        wait_held(1'b0, 200, "multi_release");

        // Reset while HELD: immediate column 0, no release pulse ever
        push(1'b0, 2'd0, 2'd3);
        keys[0*4+3] = 1'b1;
        wait_held(1'b1, 200, "rst_pre_held");
        repeat (5) @(negedge clk);
        rel_before = rel_count;
        reset = 1'b0;
        #1;
        check("rst_cols_async", 32'(cols), 32'h1);
        check("rst_held_async", 32'(key_held), 32'h0);
        repeat (3) @(negedge clk);
        keys  = '0;
        reset = 1'b1;
        check("rst_restart_col0", 32'(cols), 32'h1);
        repeat (60) @(negedge clk);
        check("rst_no_release", 32'(rel_count - rel_before), 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameters: N_COLS, default 4, number of column drive lines (>=2).
REQ-002 SHALL have parameters: N_ROWS, default 4, number of row sense lines (>=1).
REQ-003 SHALL have parameters: SCAN_DIV, default 4, clk cycles per scan tick (>=1).
REQ-004 SHALL have parameters: DEBOUNCE, default 3, consecutive agreeing ticks required to confirm press or release (>=1).
REQ-005 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: rows  input  N_ROWS  raw keypad row lines, active-high, asynchronous to clk.
REQ-008 SHALL have port: cols  output  N_COLS  one-hot column drive.
REQ-009 SHALL have port: key_valid  output  1  one-cycle pulse on confirmed press.
REQ-010 SHALL have port: key_row  output  max(1,$clog2(N_ROWS))  row index of confirmed key.
REQ-011 SHALL have port: key_col  output  max(1,$clog2(N_COLS))  column index of confirmed key.
REQ-012 SHALL have port: key_held  output  1  level, high from press confirm to release confirm.
REQ-013 SHALL have port: key_release  output  1  one-cycle pulse on confirmed release.

Function
REQ-014 SHALL pass rows through a 2-flop synchronizer; all decisions use the synchronized value (rows_s).
REQ-015 SHALL run a free-running tick counter 0..SCAN_DIV-1; tick asserted in the cycle the counter equals SCAN_DIV-1; counter wraps to 0.
REQ-016 SHALL implement four states: SCAN, PRESS_DB, HELD, RELEASE_DB; state changes only on tick cycles.
REQ-017 SCAN: cols = one-hot of col_idx; at tick, rows_s==0 -> col_idx advances, N_COLS-1 wraps to 0; rows_s!=0 -> latch lowest set row index and col_idx, db_cnt=1, go PRESS_DB (or HELD directly if DEBOUNCE==1).
REQ-018 PRESS_DB: cols frozen; at tick, latched row high -> db_cnt++; db_cnt reaching DEBOUNCE -> go HELD, pulse key_valid; latched row low -> go SCAN with col_idx advanced.
REQ-019 HELD: key_held=1, cols frozen; at tick, latched row low -> db_cnt=1, go RELEASE_DB (or release directly if DEBOUNCE==1); other rows ignored (no rollover).
REQ-020 RELEASE_DB: at tick, latched row low -> db_cnt++; reaching DEBOUNCE -> pulse key_release, key_held=0, go SCAN with col_idx advanced; latched row high -> back to HELD, no pulse.
REQ-021 Simultaneous rows in one column SHALL resolve to the lowest row index.
REQ-022 key_row/key_col SHALL update only on press confirm and hold value until next confirm.
REQ-023 key_valid and key_release SHALL be registered, high exactly one cycle, the cycle after the confirming tick edge; never both high.
REQ-024 Non-power-of-two N_COLS SHALL wrap at N_COLS-1, never driving an out-of-range column.

Reset
REQ-025 reset low SHALL immediately force: state SCAN, col_idx 0, cols = 1 (column 0), tick and db counters 0, synchronizer 0, key_valid/key_release/key_held 0, key_row/key_col 0.
REQ-026 reset asserted in any state, including mid-debounce or HELD, SHALL abort with no pulse emitted; scanning restarts at column 0 after release.

Verification (N_COLS=4, N_ROWS=4, SCAN_DIV=4, DEBOUNCE=3; bench keypad model drives rows from cols)
REQ-027 Idle scan: no keys -> cols 0001,0010,0100,1000,0001, each held 4 cycles, no pulses.
REQ-028 Press: key (row 2, col 1) held long -> single key_valid, key_row=2, key_col=1, key_held=1, cols stays 0010.
REQ-029 Bounce: row 2 high for only 1 tick in col 1 -> no key_valid, next cols 0100.
REQ-030 Release: from REQ-028 drop key -> after 3 low ticks single key_release, key_held=0, next cols 0100; release glitch of 1 tick -> stays HELD, no pulse.
REQ-031 Multi-row: rows 1 and 3 pressed in col 2 -> key_row=1, key_col=2.
REQ-032 Reset mid-HELD: reset=0 -> cols=0001, key_held=0 same cycle; no key_release ever emitted.
